// File: rtl/mem_port_arbiter.sv
// Shares one ready-handshaked memory between instruction fetch and the data port.
// Data has fixed priority; the watchdog aborts accesses the memory never completes.
module mem_port_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int TIMEOUT    = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_instr_req,
  input  logic [ADDR_WIDTH-1:0] i_instr_addr,
  output logic [DATA_WIDTH-1:0] o_instr_rdata,
  output logic                  o_instr_valid,
  input  logic                  i_data_req,
  input  logic                  i_data_we,
  input  logic [ADDR_WIDTH-1:0] i_data_addr,
  input  logic [DATA_WIDTH-1:0] i_data_wdata,
  output logic [DATA_WIDTH-1:0] o_data_rdata,
  output logic                  o_data_valid,
  output logic                  o_stall_IF,
  output logic                  o_stall_M,
  output logic                  o_mem_req,
  output logic                  o_mem_we,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic [DATA_WIDTH-1:0] o_mem_wdata,
  input  logic                  i_mem_ready,
  input  logic [DATA_WIDTH-1:0] i_mem_rdata,
  output logic                  o_err
);

  typedef enum logic [1:0] {IDLE, INSTR, DATA} state_t;

  localparam bit          WD_EN   = (TIMEOUT != 0);
  localparam logic [15:0] TO_LAST = WD_EN ? 16'(TIMEOUT - 1) : 16'd0;

  state_t                state, state_d;
  logic [15:0]           wait_cnt, wait_cnt_d;
  logic                  mem_req_d, mem_we_d;
  logic [ADDR_WIDTH-1:0] mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_wdata_d, instr_rdata_d, data_rdata_d;
  logic                  instr_valid_d, data_valid_d, err_d;
  logic                  timeout, done;

  assign o_stall_IF = i_instr_req & ~o_instr_valid;
  assign o_stall_M  = i_data_req  & ~o_data_valid;

  // Counter holds TIMEOUT-1 on the last cycle it is allowed to wait.
  assign timeout = WD_EN && !i_mem_ready && (wait_cnt == TO_LAST);
  assign done    = i_mem_ready || timeout;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  always_comb begin
    state_d       = state;
    wait_cnt_d    = wait_cnt;
    mem_req_d     = o_mem_req;
    mem_we_d      = o_mem_we;
    mem_addr_d    = o_mem_addr;
    mem_wdata_d   = o_mem_wdata;
    instr_rdata_d = o_instr_rdata;
    data_rdata_d  = o_data_rdata;
    instr_valid_d = 1'b0;
    data_valid_d  = 1'b0;
    err_d         = o_err;
    case (state)
      IDLE: begin
        wait_cnt_d = '0;
        if (i_data_req) begin
          state_d     = DATA;
          mem_req_d   = 1'b1;
          mem_we_d    = i_data_we;
          mem_addr_d  = i_data_addr;
          mem_wdata_d = i_data_wdata;
        end else if (i_instr_req) begin
          state_d    = INSTR;
          mem_req_d  = 1'b1;
          mem_we_d   = 1'b0;
          mem_addr_d = i_instr_addr;
        end
      end
      INSTR, DATA: begin
        if (done) begin
          state_d    = IDLE;
          mem_req_d  = 1'b0;
          wait_cnt_d = '0;
          if (timeout) err_d = 1'b1;
          if (state == INSTR) begin
            instr_valid_d = 1'b1;
            instr_rdata_d = i_mem_ready ? i_mem_rdata : '0;
          end else begin
            data_valid_d = 1'b1;
            // Writes leave the load-data register untouched.
            if (!o_mem_we) data_rdata_d = i_mem_ready ? i_mem_rdata : '0;
          end
        end else begin
          wait_cnt_d = wait_cnt + 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt      <= '0;
      o_mem_req     <= 1'b0;
      o_mem_we      <= 1'b0;
      o_mem_addr    <= '0;
      o_mem_wdata   <= '0;
      o_instr_rdata <= '0;
      o_data_rdata  <= '0;
      o_instr_valid <= 1'b0;
      o_data_valid  <= 1'b0;
      o_err         <= 1'b0;
    end else begin
      wait_cnt      <= wait_cnt_d;
      o_mem_req     <= mem_req_d;
      o_mem_we      <= mem_we_d;
      o_mem_addr    <= mem_addr_d;
      o_mem_wdata   <= mem_wdata_d;
      o_instr_rdata <= instr_rdata_d;
      o_data_rdata  <= data_rdata_d;
      o_instr_valid <= instr_valid_d;
      o_data_valid  <= data_valid_d;
      o_err         <= err_d;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: memory responder model plus completion scoreboards.
module tb_mem_port_arbiter;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_instr_req = 1'b0;
  logic [31:0] i_instr_addr = '0;
  logic [31:0] o_instr_rdata;
  logic        o_instr_valid;
  logic        i_data_req = 1'b0;
  logic        i_data_we = 1'b0;
  logic [31:0] i_data_addr = '0;
  logic [31:0] i_data_wdata = '0;
  logic [31:0] o_data_rdata;
  logic        o_data_valid;
  logic        o_stall_IF, o_stall_M;
  logic        o_mem_req, o_mem_we;
  logic [31:0] o_mem_addr, o_mem_wdata;
  logic        i_mem_ready = 1'b0;
  logic [31:0] i_mem_rdata = '0;
  logic        o_err;

  int checks = 0;
  int errors = 0;
  int wait_states = 0;
  bit stuck = 0;
  int mcnt = 0;
  logic [31:0] iq[$];
  logic [31:0] dq[$];

  mem_port_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst),
    .i_instr_req(i_instr_req), .i_instr_addr(i_instr_addr),
    .o_instr_rdata(o_instr_rdata), .o_instr_valid(o_instr_valid),
    .i_data_req(i_data_req), .i_data_we(i_data_we), .i_data_addr(i_data_addr),
    .i_data_wdata(i_data_wdata), .o_data_rdata(o_data_rdata), .o_data_valid(o_data_valid),
    .o_stall_IF(o_stall_IF), .o_stall_M(o_stall_M),
    .o_mem_req(o_mem_req), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr),
    .o_mem_wdata(o_mem_wdata), .i_mem_ready(i_mem_ready), .i_mem_rdata(i_mem_rdata),
    .o_err(o_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Memory model: ready after wait_states cycles of o_mem_req, data = addr + 3.
  always @(negedge clk) begin
    if (!o_mem_req) begin
      mcnt = 0;
      i_mem_ready = 1'b0;
    end else begin
      i_mem_ready = !stuck && (mcnt == wait_states);
      i_mem_rdata = i_mem_ready ? o_mem_addr + 32'd3 : 32'hFFFF_FFFF;
      mcnt++;
    end
  end

  // Scoreboard: every valid pulse pops the oldest expected read data.
  always @(negedge clk) begin
    if (!rst) begin
      if (o_instr_valid) begin
        chk("instr_pending", 64'(iq.size() != 0), 64'd1);
        if (iq.size() != 0) chk("instr_rdata", 64'(o_instr_rdata), 64'(iq.pop_front()));
      end
      if (o_data_valid) begin
        chk("data_pending", 64'(dq.size() != 0), 64'd1);
        if (dq.size() != 0) chk("data_rdata", 64'(o_data_rdata), 64'(dq.pop_front()));
      end
    end
  end

  initial begin
    int hi_cnt;
    bit seen;
    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_mem_req", 64'(o_mem_req), 64'd0);
    chk("rst_mem_addr", 64'(o_mem_addr), 64'd0);
    chk("rst_valids", 64'({o_instr_valid, o_data_valid}), 64'd0);
    chk("rst_err", 64'(o_err), 64'd0);
    chk("rst_rdata", 64'({o_instr_rdata, o_data_rdata}), 64'd0);
    i_instr_req = 1'b1;
    #1 chk("rst_stall_follows", 64'(o_stall_IF), 64'd1);
    i_instr_req = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    // Single fetch, zero wait
    @(negedge clk);
    i_instr_req = 1'b1; i_instr_addr = 32'h10; iq.push_back(32'h13);
    #1 chk("f1_stall_req", 64'(o_stall_IF), 64'd1);
    @(negedge clk);
    chk("f1_mem_req", 64'(o_mem_req), 64'd1);
    chk("f1_mem_addr", 64'(o_mem_addr), 64'h10);
    chk("f1_mem_we", 64'(o_mem_we), 64'd0);
    chk("f1_no_valid", 64'(o_instr_valid), 64'd0);
    chk("f1_stall", 64'(o_stall_IF), 64'd1);
    @(negedge clk);
    chk("f1_valid", 64'(o_instr_valid), 64'd1);
    chk("f1_stall_clr", 64'(o_stall_IF), 64'd0);
    chk("f1_req_drop", 64'(o_mem_req), 64'd0);
    i_instr_req = 1'b0;
    @(negedge clk);
    chk("f1_pulse", 64'(o_instr_valid), 64'd0);

    // Collision: data read first, fetch accepted in the data-valid cycle
    i_instr_req = 1'b1; i_instr_addr = 32'h20;
    i_data_req = 1'b1; i_data_we = 1'b0; i_data_addr = 32'h100;
    dq.push_back(32'h103); iq.push_back(32'h23);
    @(negedge clk);
    chk("col_data_addr", 64'(o_mem_addr), 64'h100);
    chk("col_stall_m", 64'(o_stall_M), 64'd1);
    @(negedge clk);
    chk("col_dvalid", 64'(o_data_valid), 64'd1);
    chk("col_ivalid_lo", 64'(o_instr_valid), 64'd0);
    i_data_req = 1'b0;
    @(negedge clk);
    chk("col_instr_addr", 64'(o_mem_addr), 64'h20);
    @(negedge clk);
    chk("col_ivalid", 64'(o_instr_valid), 64'd1);
    i_instr_req = 1'b0;
    @(negedge clk);

    // Store with 3 wait states; wdata changes after accept
    wait_states = 3;
    i_data_req = 1'b1; i_data_we = 1'b1; i_data_addr = 32'h200; i_data_wdata = 32'hDEADBEEF;
    dq.push_back(32'h103);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i == 0) i_data_wdata = 32'h1234_5678;
      chk("st_req", 64'(o_mem_req), 64'd1);
      chk("st_we", 64'(o_mem_we), 64'd1);
      chk("st_wdata", 64'(o_mem_wdata), 64'hDEADBEEF);
      chk("st_no_valid", 64'(o_data_valid), 64'd0);
    end
    @(negedge clk);
    chk("st_valid", 64'(o_data_valid), 64'd1);
    i_data_req = 1'b0; i_data_we = 1'b0;
    wait_states = 0;
    @(negedge clk);

    // Watchdog timeout on a data read
    stuck = 1;
    i_data_req = 1'b1; i_data_addr = 32'h300;
    dq.push_back(32'h0);
    hi_cnt = 0; seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (o_data_valid) seen = 1;
      else if (o_mem_req) hi_cnt++;
    end
    chk("to_valid_seen", 64'(seen), 64'd1);
    chk("to_req_cycles", 64'(hi_cnt), 64'd8);
    chk("to_err", 64'(o_err), 64'd1);
    i_data_req = 1'b0;
    stuck = 0;
    @(negedge clk);
    i_instr_req = 1'b1; i_instr_addr = 32'h40; iq.push_back(32'h43);
    repeat (2) @(negedge clk);
    chk("to_good_valid", 64'(o_instr_valid), 64'd1);
    chk("to_err_sticky", 64'(o_err), 64'd1);
    i_instr_req = 1'b0;
    @(negedge clk);

    // Asynchronous reset during a data access
    wait_states = 5;
    i_data_req = 1'b1; i_data_addr = 32'h400;
    repeat (2) @(negedge clk);
    chk("rm_in_flight", 64'(o_mem_req), 64'd1);
    #2 rst = 1'b1;
    #1 chk("rm_req_async", 64'(o_mem_req), 64'd0);
    chk("rm_err_clr", 64'(o_err), 64'd0);
    i_data_req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    wait_states = 0;
    repeat (3) @(negedge clk);
    chk("rm_no_valid", 64'({o_instr_valid, o_data_valid, o_mem_req}), 64'd0);
    i_instr_req = 1'b1; i_instr_addr = 32'h50; iq.push_back(32'h53);
    @(negedge clk);
    chk("rm_fetch_addr", 64'(o_mem_addr), 64'h50);
    @(negedge clk);
    chk("rm_fetch_valid", 64'(o_instr_valid), 64'd1);
    i_instr_req = 1'b0;
    @(negedge clk);

    // Streaming fetch, request held high
    i_instr_req = 1'b1; i_instr_addr = 32'h0;
    for (int k = 0; k < 4; k++) iq.push_back(32'(4 * k + 3));
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("sf_addr", 64'(o_mem_addr), 64'(4 * k));
      chk("sf_gap", 64'(o_instr_valid), 64'd0);
      @(negedge clk);
      chk("sf_valid", 64'(o_instr_valid), 64'd1);
      if (k == 3) i_instr_req = 1'b0;
      else        i_instr_addr = 32'(4 * (k + 1));
    end
    repeat (2) @(negedge clk);

    chk("iq_drained", 64'(iq.size()), 64'd0);
    chk("dq_drained", 64'(dq.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "bench time limit");
  end
endmodule
